// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the FIFO access controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_ctrl_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 10;
  localparam int LEVEL_W    = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among req, searching from a registered pointer.
// Latency: grant is combinational; the pointer moves at the edge after an advance.
// Backpressure: a request is simply not granted until it wins; pointer holds without advance.
// Ports: clock/reset (sync, active-high), req[N], advance (winner consumed),
//        grant[N] one-hot or zero, ptr = index currently holding highest priority.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  // Walk N positions starting at ptr, wrapping modulo N; first requester found wins.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win_idx    = idx;
        found      = 1'b1;
      end
    end
  end

  // After a grant, the requester just served drops to lowest priority.
  assign ptr_nxt = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Shares one single-port FIFO between N_REQ writers and one reader; owns occupancy and flush.
// Latency: grants/strobes combinational; level updates next edge; rd_valid one cycle after rd_grant.
// Backpressure: writers stall at full, reader stalls at empty, all stall during FLUSH.
// Ports: wr_req/wr_data/wr_grant (writers), rd_req/rd_grant/rd_valid (reader),
//        flush_req/flush_done, level/full/empty, fifo_* pins driving the FIFO.
module fifo_access_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         wr_req,
  input  logic [N_REQ*WIDTH-1:0]   wr_data,
  output logic [N_REQ-1:0]         wr_grant,
  input  logic                     rd_req,
  output logic                     rd_grant,
  output logic                     rd_valid,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic [LEVEL_W-1:0]       level,
  output logic                     full,
  output logic                     empty,
  output logic                     fifo_enable,
  output logic                     fifo_read,
  output logic                     fifo_write,
  output logic                     fifo_reset,
  output logic [WIDTH-1:0]         fifo_data_in
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  ctrl_state_t          state_q, state_d;
  op_t                  last_op_q, op;
  logic [LEVEL_W-1:0]   level_q;
  logic                 rd_valid_q;
  logic                 rd_cand, wr_cand;
  logic [N_REQ-1:0]     arb_grant;
  logic [PW-1:0]        arb_ptr;

  assign level = level_q;
  assign full  = (level_q == LEVEL_W'(DEPTH));
  assign empty = (level_q == '0);

  // Everything is masked while reset is high so nothing is granted before the state is known.
  assign rd_cand = !reset && (state_q == RUN) && rd_req && !empty;
  assign wr_cand = !reset && (state_q == RUN) && (|wr_req) && !full;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_wr_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (wr_req),
    .advance (fifo_write),
    .grant   (arb_grant),
    .ptr     (arb_ptr)
  );

  // Op selection and next state.
  always_comb begin
    op      = OP_NONE;
    state_d = state_q;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (rd_cand && wr_cand) begin
            // Alternate under contention so neither side starves.
            op = (last_op_q == OP_READ) ? OP_WRITE : OP_READ;
          end else if (wr_cand) begin
            op = OP_WRITE;
          end else if (rd_cand) begin
            op = OP_READ;
          end
          if (flush_req) begin
            state_d = FLUSH;
          end
        end
        FLUSH: begin
          if (level_q != '0) begin
            op = OP_READ;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign fifo_write  = (op == OP_WRITE);
  assign fifo_read   = (op == OP_READ);
  assign fifo_reset  = reset;
  assign fifo_enable = reset || fifo_read || fifo_write;
  assign wr_grant    = fifo_write ? arb_grant : '0;
  // Flush reads are internal drains, never presented to the consumer.
  assign rd_grant    = fifo_read && (state_q == RUN);
  assign rd_valid    = rd_valid_q;
  assign flush_done  = !reset && (state_q == FLUSH) && (level_q == '0);

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (wr_grant[i]) begin
        fifo_data_in = wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      last_op_q  <= OP_READ;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_grant;
      if (fifo_write) begin
        level_q <= level_q + LEVEL_W'(1);
      end else if (fifo_read) begin
        level_q <= level_q - LEVEL_W'(1);
      end
      if (op != OP_NONE) begin
        last_op_q <= op;
      end
    end
  end

  // The FIFO has a single port: read and write must never coincide.
  a_excl_strobes : assert property (@(posedge clock) disable iff (reset)
    !(fifo_read && fifo_write));

  a_ptr_range : assert property (@(posedge clock) disable iff (reset)
    int'(arb_ptr) < N_REQ);

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Directed bench for fifo_access_ctrl: a vector table applied one row per cycle,
// inputs driven just after the rising edge and outputs compared on the falling edge.
module tb_fifo_access_ctrl;

  localparam int NR = 4;
  localparam int W  = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [NR-1:0]   wr_req;
  logic [NR*W-1:0] wr_data;
  logic [NR-1:0]   wr_grant;
  logic            rd_req;
  logic            rd_grant;
  logic            rd_valid;
  logic            flush_req;
  logic            flush_done;
  logic [3:0]      level;
  logic            full;
  logic            empty;
  logic            fifo_enable;
  logic            fifo_read;
  logic            fifo_write;
  logic            fifo_reset;
  logic [W-1:0]    fifo_data_in;

  always #5 clock = ~clock;

  fifo_access_ctrl #(.N_REQ(NR), .WIDTH(W), .DEPTH(10)) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_req       (wr_req),
    .wr_data      (wr_data),
    .wr_grant     (wr_grant),
    .rd_req       (rd_req),
    .rd_grant     (rd_grant),
    .rd_valid     (rd_valid),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .fifo_enable  (fifo_enable),
    .fifo_read    (fifo_read),
    .fifo_write   (fifo_write),
    .fifo_reset   (fifo_reset),
    .fifo_data_in (fifo_data_in)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  wreq;
    logic        rreq;
    logic        fl;
    logic [3:0]  wg;
    logic        rg;
    logic        frd;
    logic        fwr;
    logic [15:0] din;
    logic [3:0]  lvl;
    logic        rv;
    logic        fd;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(input int rst, input int wreq, input int rreq, input int fl,
                             input int wg, input int rg, input int frd, input int fwr,
                             input int din, input int lvl, input int rv, input int fd);
    vec_t r;
    r.rst = 1'(rst);  r.wreq = 4'(wreq); r.rreq = 1'(rreq); r.fl  = 1'(fl);
    r.wg  = 4'(wg);   r.rg   = 1'(rg);   r.frd  = 1'(frd);  r.fwr = 1'(fwr);
    r.din = 16'(din); r.lvl  = 4'(lvl);  r.rv   = 1'(rv);   r.fd  = 1'(fd);
    return r;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", nm, row, act, exp);
    end
  endtask

  initial begin
    // Each requester i presents A000+i for the whole run.
    for (int i = 0; i < NR; i++) wr_data[i*W +: W] = 16'hA000 + 16'(i);

    // Round-robin from empty: requesters 0..3 in order.
    tbl.push_back(v(0, 'hF, 0, 0, 'h1, 0, 0, 1, 'hA000, 0, 0, 0));
    tbl.push_back(v(0, 'hF, 0, 0, 'h2, 0, 0, 1, 'hA001, 1, 0, 0));
    tbl.push_back(v(0, 'hF, 0, 0, 'h4, 0, 0, 1, 'hA002, 2, 0, 0));
    tbl.push_back(v(0, 'hF, 0, 0, 'h8, 0, 0, 1, 'hA003, 3, 0, 0));
    // Reset with requests high: nothing granted, FIFO reset strobed.
    tbl.push_back(v(1, 'hF, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0));
    // Fill to full from requester 2, then two stalled attempts.
    for (int k = 0; k < 10; k++) tbl.push_back(v(0, 'h4, 0, 0, 'h4, 0, 0, 1, 'hA002, k, 0, 0));
    tbl.push_back(v(0, 'h4, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0));
    tbl.push_back(v(0, 'h4, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0));
    // At full a read still proceeds while the write stalls; then drain to 5.
    tbl.push_back(v(0, 'h4, 1, 0, 0, 1, 1, 0, 0, 10, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(v(0, 0, 1, 0, 0, 1, 1, 0, 0, 9 - k, 1, 0));
    // Contention at level 5: last op was a read, so W,R,W,R,W,R.
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(v(0, 'h2, 1, 0, 'h2, 0, 0, 1, 'hA001, 5, 1, 0));
      tbl.push_back(v(0, 'h2, 1, 0, 0, 1, 1, 0, 0, 6, 0, 0));
    end
    tbl.push_back(v(0, 'h2, 0, 0, 'h2, 0, 0, 1, 'hA001, 5, 1, 0));
    // Flush requested in a cycle that also grants a write: the write completes, level 7.
    tbl.push_back(v(0, 'h2, 0, 1, 'h2, 0, 0, 1, 'hA001, 6, 0, 0));
    // Seven drain reads, no grants, no rd_valid; a repeated flush_req is ignored.
    for (int k = 0; k < 7; k++) tbl.push_back(v(0, 'h2, 0, (k == 2) ? 1 : 0, 0, 0, 1, 0, 0, 7 - k, 0, 0));
    tbl.push_back(v(0, 'h2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // First RUN cycle after flush grants the held write.
    tbl.push_back(v(0, 'h2, 0, 0, 'h2, 0, 0, 1, 'hA001, 0, 0, 0));
    tbl.push_back(v(0, 'h2, 0, 0, 'h2, 0, 0, 1, 'hA001, 1, 0, 0));
    // Read, then reset in the following cycle: rd_valid high now, cleared after the edge.
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 1, 0, 0, 2, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    // Flush from empty: done one cycle after entry.
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Pointer was reset, so requester 0 wins.
    tbl.push_back(v(0, 'hF, 0, 0, 'h1, 0, 0, 1, 'hA000, 0, 0, 0));
    // Flush at level 1, reset lands when level reaches 0: no flush_done.
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Initial reset: two cycles with every request asserted.
    reset = 1'b1; wr_req = 4'hF; rd_req = 1'b1; flush_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk("rst_wr_grant", c, 32'(wr_grant), 32'h0);
      chk("rst_rd_grant", c, 32'(rd_grant), 32'h0);
      chk("rst_fifo_reset", c, 32'(fifo_reset), 32'h1);
      chk("rst_fifo_enable", c, 32'(fifo_enable), 32'h1);
      chk("rst_strobes", c, 32'({fifo_read, fifo_write}), 32'h0);
      chk("rst_data_in", c, 32'(fifo_data_in), 32'h0);
    end
    @(posedge clock); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      reset     = tbl[i].rst;
      wr_req    = tbl[i].wreq;
      rd_req    = tbl[i].rreq;
      flush_req = tbl[i].fl;
      @(negedge clock);
      chk("wr_grant",     i, 32'(wr_grant),     32'(tbl[i].wg));
      chk("rd_grant",     i, 32'(rd_grant),     32'(tbl[i].rg));
      chk("fifo_read",    i, 32'(fifo_read),    32'(tbl[i].frd));
      chk("fifo_write",   i, 32'(fifo_write),   32'(tbl[i].fwr));
      chk("fifo_data_in", i, 32'(fifo_data_in), 32'(tbl[i].din));
      chk("level",        i, 32'(level),        32'(tbl[i].lvl));
      chk("rd_valid",     i, 32'(rd_valid),     32'(tbl[i].rv));
      chk("flush_done",   i, 32'(flush_done),   32'(tbl[i].fd));
      chk("fifo_enable",  i, 32'(fifo_enable),  32'(tbl[i].rst | tbl[i].frd | tbl[i].fwr));
      chk("fifo_reset",   i, 32'(fifo_reset),   32'(tbl[i].rst));
      chk("full",         i, 32'(full),         32'(tbl[i].lvl == 4'd10));
      chk("empty",        i, 32'(empty),        32'(tbl[i].lvl == 4'd0));
      chk("excl_strobes", i, 32'(fifo_read & fifo_write), 32'h0);
      @(posedge clock); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
